qeip_clock_enable_bank: RTL and testbench
=========================================

// Module: qeip_clock_enable_bank
// PURPOSE
//  Parametrised on-chip clock generator for the QEIP platform.
//  From one system clock it derives NUM_CH divided clocks, each with a
//  clock-enable pulse and a registered square-wave output.
//  Models PLL lock behaviour: outputs stay gated until a lock interval has elapsed.
//  Dividers are reprogrammable at run time through a req/ack handshake; each
//  reprogram forces a relock. Sits between the platform clock source and the
//  QEIP subsystems.
// PARAMETERS
//  NUM_CH       4   number of divided-clock channels
//  DIV_W        8   width of each channel's divide ratio
//  LOCK_CYCLES  16  cycles spent in LOCKING before locked asserts (>=1)
//  DEFAULT_DIV  2   divide ratio loaded into every channel on reset
// PORTS
//  clk      in   1             system clock (single clock domain)
//  rst      in   1             synchronous reset, active-high
//  cfg_req  in   1             reprogram request, level; held until cfg_ack
//  cfg_div  in   NUM_CH*DIV_W  new divide ratios; channel i = bits [i*DIV_W +: DIV_W]
//  cfg_ack  out  1             one-cycle pulse: cfg_div captured
//  locked   out  1             dividers running, outputs valid
//  clk_en   out  NUM_CH        per-channel enable: 1-cycle pulse every E_i cycles
//  clk_div  out  NUM_CH        per-channel divided square wave
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All outputs are registered.
//  - Reset values: state=LOCKING, lock_cnt=0, div_reg[i]=DEFAULT_DIV, cnt[i]=0,
//    cfg_ack=0, locked=0, clk_en=0, clk_div=0.
//  - rst wins over every other event. Asserting rst mid-operation discards
//    programmed ratios (they return to DEFAULT_DIV) and drops an in-flight
//    request without acking it.
//  - FSM LOCKING:
//    - lock_cnt increments each cycle.
//    - At lock_cnt==LOCK_CYCLES-1: go to LOCKED and register locked=1.
//    - Result: locked first reads 1 exactly LOCK_CYCLES cycles after the first
//      cycle with rst=0.
//    - cfg_req is ignored in this state (no ack; requester keeps holding).
//    - cnt, clk_en and clk_div are held at 0.
//  - FSM LOCKED, cfg_req=1 sampled:
//    - div_reg <= cfg_div and cfg_ack=1 on the next cycle (single pulse).
//    - The same edge sets locked=0, state=LOCKING, lock_cnt=0, all cnt=0, and
//      clears clk_en/clk_div.
//    - cfg_req sampled in the very cycle locked first reads 1 is accepted.
//  - Effective ratio: E_i = (div_reg[i]==0) ? 1 : div_reg[i]. A zero ratio is
//    legal and behaves as 1.
//  - Channel counters, per cycle while locked=1:
//    - cnt[i] counts 0..E_i-1 and wraps to 0; it starts at 0 in the first
//      cycle locked=1.
//    - clk_en[i] <= (cnt[i]==E_i-1). With locked rising at cycle T, pulses
//      occur at T+E_i, T+2E_i, ...
//    - E_i=1: clk_en[i] stays high continuously from T+1.
//    - clk_div[i] <= (cnt[i] >= (E_i>>1)). High for E_i-floor(E_i/2) cycles of
//      each period, so high half >= low half.
//    - E_i=1: clk_div[i] is constant 1 from T+1.
//  - Counter width is DIV_W; the compare uses E_i. Changing div_reg is possible
//    only through a relock, so no mid-period ratio changes occur.
//  - Channels are independent and are phase-aligned at each lock.
// TESTING
//  - Reset: hold rst 3 cycles then release. Outputs 0 throughout. locked rises
//    exactly 16 cycles after release; ch0 (div 2) clk_en pulses on every 2nd
//    cycle after lock; clk_div alternates 0,1.
//  - Reprogram: while locked, set cfg_req=1, cfg_div={8'd0,8'd5,8'd3,8'd4}.
//    Expect cfg_ack one cycle later and locked=0 on the same edge. After 16
//    cycles locked=1; periods are ch0=4, ch1=3, ch2=5, ch3=1. ch1 clk_div
//    pattern is 0,1,1; ch3 clk_en/clk_div constant 1.
//  - Request during LOCKING: raise cfg_req 2 cycles after reset release. No ack
//    until locked; ack arrives one cycle after locked rises; new ratios apply.
//  - Reset mid-lock/mid-run: program div=7, then assert rst while locked.
//    Expect locked=0, clk_en=0, clk_div=0 next cycle. After relock, every
//    channel runs at div 2.
//  - Reset during pending cfg_req: rst and cfg_req high together. cfg_ack never
//    pulses; ratios stay DEFAULT_DIV.
//  - Parameter sweep: NUM_CH=1, DIV_W=4, LOCK_CYCLES=1, ratio 15. locked rises 1
//    cycle after release; clk_en period is 15; clk_div is low 7 cycles, high 8.

Source files
------------

// File: rtl/qeip_clock_enable_bank.sv
// rtl/qeip_clock_enable_bank.sv - divided clock-enable bank with lock interval and reprogram handshake
// Outputs stay gated while LOCKING; every accepted reprogram restarts the lock interval.
module qeip_clock_enable_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_req,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  output logic                    cfg_ack,
  output logic                    locked,
  output logic [NUM_CH-1:0]       clk_en,
  output logic [NUM_CH-1:0]       clk_div
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_CYCLES - 1);

  localparam logic [0:0] S_LOCKING = 1'b0;
  localparam logic [0:0] S_LOCKED  = 1'b1;

  logic [0:0]                    r_state;
  logic [LCW-1:0]                r_lock_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]  r_div;
  logic [NUM_CH-1:0][DIV_W-1:0]  r_cnt;
  logic                          r_cfg_ack;
  logic                          r_locked;
  logic [NUM_CH-1:0]             r_clk_en;
  logic [NUM_CH-1:0]             r_clk_div;

  logic [NUM_CH-1:0][DIV_W-1:0]  w_last;
  logic [NUM_CH-1:0][DIV_W-1:0]  w_half;
  logic [NUM_CH-1:0]             w_wrap;

  // A zero ratio is treated as 1: last count 0, high threshold 0.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_div[i] == '0) begin
        w_last[i] = '0;
        w_half[i] = '0;
      end else begin
        w_last[i] = r_div[i] - DIV_W'(1);
        w_half[i] = r_div[i] >> 1;
      end
      w_wrap[i] = (r_cnt[i] == w_last[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_LOCKING;
      r_lock_cnt <= '0;
      r_cfg_ack  <= 1'b0;
      r_locked   <= 1'b0;
      r_clk_en   <= '0;
      r_clk_div  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i] <= DIV_W'(DEFAULT_DIV);
        r_cnt[i] <= '0;
      end
    end else begin
      r_cfg_ack <= 1'b0;
      if (r_state == S_LOCKING) begin
        r_cnt     <= '0;
        r_clk_en  <= '0;
        r_clk_div <= '0;
        if (r_lock_cnt == LOCK_LAST) begin
          r_state    <= S_LOCKED;
          r_locked   <= 1'b1;
          r_lock_cnt <= '0;
        end else begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end
      end else if (cfg_req) begin
        r_div      <= cfg_div;
        r_cfg_ack  <= 1'b1;
        r_state    <= S_LOCKING;
        r_locked   <= 1'b0;
        r_lock_cnt <= '0;
        r_cnt      <= '0;
        r_clk_en   <= '0;
        r_clk_div  <= '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          r_clk_en[i]  <= w_wrap[i];
          r_clk_div[i] <= (r_cnt[i] >= w_half[i]);
          r_cnt[i]     <= w_wrap[i] ? '0 : r_cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  assign cfg_ack = r_cfg_ack;
  assign locked  = r_locked;
  assign clk_en  = r_clk_en;
  assign clk_div = r_clk_div;

endmodule

// File: tb/tb_qeip_clock_enable_bank.sv
// tb/tb_qeip_clock_enable_bank.sv - self-checking bench for qeip_clock_enable_bank
// Reference model derives every output from the lock start cycle and the programmed ratios.
module tb_qeip_clock_enable_bank;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_req;
  logic [31:0] cfg_div;
  logic        cfg_ack, locked;
  logic [3:0]  clk_en, clk_div;

  logic        rst2, cfg_req2;
  logic [3:0]  cfg_div2;
  logic        cfg_ack2, locked2;
  logic [0:0]  clk_en2, clk_div2;

  qeip_clock_enable_bank dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_div(cfg_div),
    .cfg_ack(cfg_ack), .locked(locked), .clk_en(clk_en), .clk_div(clk_div)
  );

  qeip_clock_enable_bank #(
    .NUM_CH(1), .DIV_W(4), .LOCK_CYCLES(1), .DEFAULT_DIV(15)
  ) dut_small (
    .clk(clk), .rst(rst2), .cfg_req(cfg_req2), .cfg_div(cfg_div2),
    .cfg_ack(cfg_ack2), .locked(locked2), .clk_en(clk_en2), .clk_div(clk_div2)
  );

  typedef struct {
    logic [3:0] en;
    logic [3:0] dv;
  } vec_t;
  vec_t tbl [11];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int m_start = 0;
  logic [7:0] m_div [4];
  logic m_ack = 1'b0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  function automatic void expect_outs(output logic e_lock, output logic [3:0] e_en,
                                      output logic [3:0] e_dv);
    int t;
    int k;
    int e;
    t = m_start + 16;
    e_lock = (cyc >= t);
    e_en = '0;
    e_dv = '0;
    if (cyc > t) begin
      k = cyc - t;
      for (int i = 0; i < 4; i++) begin
        e = eff(m_div[i]);
        e_en[i] = ((k % e) == 0);
        e_dv[i] = (((k - 1) % e) >= (e / 2));
      end
    end
  endfunction

  task automatic step();
    bit was_locked;
    logic e_lock;
    logic [3:0] e_en, e_dv;
    was_locked = (cyc >= m_start + 16);
    @(posedge clk);
    if (rst) begin
      m_start = cyc + 1;
      for (int i = 0; i < 4; i++) m_div[i] = 8'd2;
      m_ack = 1'b0;
    end else if (was_locked && cfg_req) begin
      for (int i = 0; i < 4; i++) m_div[i] = cfg_div[i*8 +: 8];
      m_start = cyc + 1;
      m_ack = 1'b1;
    end else begin
      m_ack = 1'b0;
    end
    cyc++;
    @(negedge clk);
    if (model_on) begin
      expect_outs(e_lock, e_en, e_dv);
      chk("model_ack", cfg_ack, m_ack);
      chk("model_locked", locked, e_lock);
      chk("model_clk_en", clk_en, e_en);
      chk("model_clk_div", clk_div, e_dv);
    end
  endtask

  task automatic wait_lock(input string name, output int n);
    n = 0;
    while (!locked && n < 100) begin
      step();
      n++;
    end
    if (!locked) chk(name, 0, 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] rand_div();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'($urandom_range(0, 9));
    return d;
  endfunction

  initial begin
    int n;
    int rel;
    int acks;
    int highs;
    int k;

    tbl[0]  = '{4'b0000, 4'b0000};
    tbl[1]  = '{4'b1000, 4'b1000};
    tbl[2]  = '{4'b1000, 4'b1010};
    tbl[3]  = '{4'b1010, 4'b1111};
    tbl[4]  = '{4'b1001, 4'b1101};
    tbl[5]  = '{4'b1100, 4'b1110};
    tbl[6]  = '{4'b1010, 4'b1010};
    tbl[7]  = '{4'b1000, 4'b1001};
    tbl[8]  = '{4'b1001, 4'b1111};
    tbl[9]  = '{4'b1010, 4'b1110};
    tbl[10] = '{4'b1100, 4'b1100};

    rst = 1'b1; cfg_req = 1'b0; cfg_div = '0;
    rst2 = 1'b1; cfg_req2 = 1'b0; cfg_div2 = '0;
    for (int i = 0; i < 4; i++) m_div[i] = 8'd2;

    // Reset held three cycles, then lock latency and default ratio 2.
    step();
    model_on = 1'b1;
    step();
    step();
    chk("reset_outputs", {cfg_ack, locked, clk_en, clk_div}, 10'd0);
    rst = 1'b0;
    wait_lock("lock_timeout", n);
    chk("lock_latency", n, 16);
    run(10);

    // Reprogram while locked.
    cfg_req = 1'b1;
    cfg_div = {8'd0, 8'd5, 8'd3, 8'd4};
    step();
    chk("reprog_ack", cfg_ack, 1'b1);
    chk("reprog_unlock", locked, 1'b0);
    cfg_req = 1'b0;
    wait_lock("relock_timeout", n);
    chk("relock_latency", n, 16);
    for (int j = 0; j < 11; j++) begin
      chk($sformatf("tbl_en_%0d", j), clk_en, tbl[j].en);
      chk($sformatf("tbl_dv_%0d", j), clk_div, tbl[j].dv);
      step();
    end
    run(20);

    // Request raised during LOCKING is acked one cycle after lock.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rel = cyc;
    step();
    step();
    cfg_req = 1'b1;
    cfg_div = rand_div();
    n = 2;
    while (!cfg_ack && n < 100) begin
      step();
      n++;
    end
    chk("locking_req_ack_latency", n, 17);
    cfg_req = 1'b0;
    wait_lock("locking_req_relock", n);
    run(40);

    // Program 7 everywhere, then reset mid-run.
    cfg_req = 1'b1;
    cfg_div = {4{8'd7}};
    step();
    cfg_req = 1'b0;
    wait_lock("div7_lock", n);
    run(12);
    rst = 1'b1;
    step();
    chk("midrun_rst_locked", locked, 1'b0);
    chk("midrun_rst_en", clk_en, 4'd0);
    chk("midrun_rst_dv", clk_div, 4'd0);
    rst = 1'b0;
    wait_lock("midrun_relock", n);
    run(20);

    // Reset together with a pending request: no ack, ratios stay default.
    rst = 1'b1;
    cfg_req = 1'b1;
    cfg_div = {4{8'd9}};
    step();
    rst = 1'b0;
    cfg_req = 1'b0;
    acks = 0;
    for (int j = 0; j < 30; j++) begin
      step();
      acks += int'(cfg_ack);
    end
    chk("pending_req_no_ack", acks, 0);

    // Randomized traffic against the model.
    for (int j = 0; j < 600; j++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (cfg_req && cfg_ack) cfg_req = 1'b0;
      else if (!cfg_req && $urandom_range(0, 14) == 0) begin
        cfg_req = 1'b1;
        cfg_div = ($urandom_range(0, 3) == 0) ? 32'($urandom) : rand_div();
      end
      step();
    end
    rst = 1'b0;
    cfg_req = 1'b0;
    run(2);

    // Single-channel variant: lock after one cycle, ratio 15.
    chk("small_reset_locked", locked2, 1'b0);
    rst2 = 1'b0;
    rel = cyc;
    step();
    highs = 0;
    for (int j = 0; j < 40; j++) begin
      k = cyc - rel - 1;
      chk("small_locked", locked2, 1'b1);
      chk("small_clk_en", clk_en2, (k > 0) && ((k % 15) == 0));
      chk("small_clk_div", clk_div2, (k > 0) && (((k - 1) % 15) >= 7));
      if (k >= 1 && k <= 15) highs += int'(clk_div2);
      step();
    end
    chk("small_high_count", highs, 8);
    chk("small_no_ack", cfg_ack2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
